// File: rtl/wsg_voice_mixer.sv
// Namco-style waveform sound generator: per-voice freq/wave/vol registers, phase accumulators, shared ROM port, saturated mix.
// Latency: sample_valid pulses 3*NUM_VOICES+1 cycles after the accepted sample_tick (10 cycles for 3 voices).
// Backpressure: none; a sample_tick arriving while a frame is in flight is dropped and raises sticky overrun.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   wr_en, ram_addr,  CPU write port; voice v owns BASE_ADDR+8v..+8v+7
//   cpu_data          (offsets 0-4 freq nibbles LS first, 5 wave_sel, 6 vol, 7 reserved)
//   sample_tick       one-cycle request for a new mixed sample
//   rom_addr/rom_data shared waveform ROM port {wave_sel, phase[4:0]}, data one cycle after address
//   sample_out        saturated mixed sample, held between frames
//   sample_valid      one-cycle pulse when sample_out updates
//   busy, overrun     frame in progress / sticky dropped-tick flag
//
// Optional build macro WSG_MASTER_ENABLE_EN adds a master-enable register (bit0) at
// BASE_ADDR+8*NUM_VOICES; while it is 0 the mixed sample is forced to zero but the
// accumulators keep advancing and sample_valid keeps pulsing.

module wsg_voice_mixer #(
    parameter int          NUM_VOICES = 3,
    parameter int          ACC_W      = 20,
    parameter logic [15:0] BASE_ADDR  = 16'h5040,
    parameter int          OUT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [15:0]      ram_addr,
    input  logic [7:0]       cpu_data,
    input  logic             sample_tick,
    output logic [7:0]       rom_addr,
    input  logic [3:0]       rom_data,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic             busy,
    output logic             overrun
);

    // Voice index width is at least one bit so a single-voice build still has a counter.
    localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    // Each product is at most 15*15 = 225 (8 bits); the sum grows by clog2(voices).
    localparam int SUM_W = 8 + $clog2(NUM_VOICES);
    localparam int WIN   = 8 * NUM_VOICES;
    // Common width for the saturation compare, wide enough for either operand.
    localparam int CW    = (SUM_W > OUT_W) ? SUM_W : OUT_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_MAC,
        S_OUT
    } state_t;

    // ------------------------------------------------------------------
    // CPU-visible voice registers
    // ------------------------------------------------------------------
    logic [19:0]     freq_q [NUM_VOICES];
    logic [2:0]      wave_q [NUM_VOICES];
    logic [3:0]      vol_q  [NUM_VOICES];

    logic [15:0]     win_off;
    logic            win_hit;
    logic [VI_W-1:0] wr_voice;
    logic [2:0]      wr_field;
    logic            out_en;
    logic            unused_cpu_hi;

    assign win_off  = ram_addr - BASE_ADDR;
    // The explicit lower-bound test keeps addresses below the window from
    // wrapping into it when BASE_ADDR is small.
    assign win_hit  = wr_en && (ram_addr >= BASE_ADDR) && (win_off < 16'(WIN));
    assign wr_voice = win_off[VI_W+2:3];
    assign wr_field = win_off[2:0];

    // Only the low nibble of the CPU byte carries register data.
    assign unused_cpu_hi = ^cpu_data[7:4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_q[v] <= '0;
                wave_q[v] <= '0;
                vol_q[v]  <= '0;
            end
        end else if (win_hit) begin
            // Writes land immediately, even mid-frame; the sequencer simply
            // picks up whatever is present when it reaches that voice.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (wr_voice == VI_W'(v)) begin
                    case (wr_field)
                        3'd0:    freq_q[v][3:0]   <= cpu_data[3:0];
                        3'd1:    freq_q[v][7:4]   <= cpu_data[3:0];
                        3'd2:    freq_q[v][11:8]  <= cpu_data[3:0];
                        3'd3:    freq_q[v][15:12] <= cpu_data[3:0];
                        3'd4:    freq_q[v][19:16] <= cpu_data[3:0];
                        3'd5:    wave_q[v]        <= cpu_data[2:0];
                        3'd6:    vol_q[v]         <= cpu_data[3:0];
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef WSG_MASTER_ENABLE_EN
    // Master enable sits in the slot just past the last voice.
    logic en_q;
    logic en_hit;

    assign en_hit = wr_en && (ram_addr == (BASE_ADDR + 16'(WIN)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q <= 1'b0;
        end else if (en_hit) begin
            en_q <= cpu_data[0];
        end
    end

    assign out_en = en_q;
`else
    assign out_en = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [VI_W-1:0]  vi_q;
    logic [SUM_W-1:0] sum_q;
    logic [ACC_W-1:0] acc_q [NUM_VOICES];
    logic [7:0]       rom_addr_q;
    logic [OUT_W-1:0] sample_out_q;
    logic             sample_valid_q;
    logic             busy_q;
    logic             overrun_q;

    // ------------------------------------------------------------------
    // Per-voice datapath for the voice currently selected by vi_q
    // ------------------------------------------------------------------
    logic [19:0]      freq_sel;
    logic [2:0]       wave_sel;
    logic [3:0]       vol_sel;
    logic [ACC_W-1:0] acc_sel;
    logic [ACC_W-1:0] acc_d;
    logic [7:0]       rom_addr_d;
    logic [7:0]       prod_d;
    logic [SUM_W-1:0] sum_d;
    logic [CW-1:0]    sum_cw;
    logic [OUT_W-1:0] sat_d;
    logic             last_voice;

    always_comb begin
        freq_sel = '0;
        wave_sel = '0;
        vol_sel  = '0;
        acc_sel  = '0;
        // Mux by comparison rather than direct indexing so a non-power-of-two
        // voice count never reads past the end of the arrays.
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (vi_q == VI_W'(v)) begin
                freq_sel = freq_q[v];
                wave_sel = wave_q[v];
                vol_sel  = vol_q[v];
                acc_sel  = acc_q[v];
            end
        end
    end

    // Phase advance wraps naturally at 2^ACC_W; the top five bits index the
    // 32-entry waveform selected by wave_sel.
    assign acc_d      = acc_sel + ACC_W'(freq_sel);
    assign rom_addr_d = {wave_sel, acc_d[ACC_W-1 -: 5]};
    assign prod_d     = {4'd0, rom_data} * {4'd0, vol_sel};
    assign sum_d      = sum_q + SUM_W'(prod_d);
    assign sum_cw     = CW'(sum_d);
    assign sat_d      = (sum_cw > CW'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : sum_cw[OUT_W-1:0];
    assign last_voice = (vi_q == VI_W'(NUM_VOICES - 1));

    // ------------------------------------------------------------------
    // Frame sequencer: IDLE -> (ADDR -> WAIT -> MAC) x voices -> OUT
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            vi_q           <= '0;
            sum_q          <= '0;
            rom_addr_q     <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc_q[v] <= '0;
            end
        end else begin
            sample_valid_q <= 1'b0;

            // busy_q covers ADDR through OUT, so a tick in the OUT cycle is
            // also a drop.
            if (sample_tick && busy_q) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (sample_tick) begin
                        state_q <= S_ADDR;
                        vi_q    <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_ADDR: begin
                    // Muted voices still advance so they stay phase-coherent.
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (vi_q == VI_W'(v)) begin
                            acc_q[v] <= acc_d;
                        end
                    end
                    rom_addr_q <= rom_addr_d;
                    state_q    <= S_WAIT;
                end

                // ROM answers one cycle after it sees the address.
                S_WAIT: begin
                    state_q <= S_MAC;
                end

                S_MAC: begin
                    sum_q <= sum_d;
                    if (last_voice) begin
                        // The output register is loaded on entry to OUT so the
                        // new sample and its valid pulse are visible during the
                        // OUT cycle itself.
                        sample_out_q   <= out_en ? sat_d : '0;
                        sample_valid_q <= 1'b1;
                        state_q        <= S_OUT;
                    end else begin
                        vi_q    <= vi_q + VI_W'(1);
                        state_q <= S_ADDR;
                    end
                end

                S_OUT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_wsg_voice_mixer.sv
// Self-checking bench for wsg_voice_mixer: directed scenarios followed by random register/tick traffic.
// Latency: expected samples and ROM addresses are timestamped by the reference model and checked on the matching cycle.
// Backpressure: ticks issued while the model says a frame is running must be dropped and flag overrun.

module tb_wsg_voice_mixer;

    localparam int          N     = 3;
    localparam int          ACC_W = 20;
    localparam int          OUT_W = 8;
    localparam logic [15:0] BASE  = 16'h5040;
    localparam int          LAT   = 3 * N + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [15:0]      ram_addr;
    logic [7:0]       cpu_data;
    logic             sample_tick;
    logic [7:0]       rom_addr;
    logic [3:0]       rom_data;
    logic [OUT_W-1:0] sample_out;
    logic             sample_valid;
    logic             busy;
    logic             overrun;

    wsg_voice_mixer #(
        .NUM_VOICES (N),
        .ACC_W      (ACC_W),
        .BASE_ADDR  (BASE),
        .OUT_W      (OUT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .ram_addr     (ram_addr),
        .cpu_data     (cpu_data),
        .sample_tick  (sample_tick),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous waveform ROM: data follows the address by one clock.
    logic [3:0] rom_mem [256];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t q_samp [$];
    exp_t q_addr [$];

    int m_freq [N];
    int m_wave [N];
    int m_vol  [N];
    int m_acc  [N];
    int m_en        = 1;
    int busy_from   = 1;
    int busy_until  = 0;
    int ovr_from    = 32'h3fff_ffff;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < N; v++) begin
            m_freq[v] = 0;
            m_wave[v] = 0;
            m_vol[v]  = 0;
            m_acc[v]  = 0;
        end
`ifdef WSG_MASTER_ENABLE_EN
        m_en = 0;
`else
        m_en = 1;
`endif
        busy_from  = 1;
        busy_until = 0;
        ovr_from   = 32'h3fff_ffff;
        q_samp.delete();
        q_addr.delete();
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        int o;
        int nib;
        o   = int'(a) - int'(BASE);
        nib = int'(d) & 15;
        if (o >= 0 && o < 8 * N) begin
            case (o % 8)
                0, 1, 2, 3, 4: m_freq[o / 8] = (m_freq[o / 8] & ~(15 << (4 * (o % 8)))) | (nib << (4 * (o % 8)));
                5:             m_wave[o / 8] = nib & 7;
                6:             m_vol[o / 8]  = nib;
                default:       ;
            endcase
        end
`ifdef WSG_MASTER_ENABLE_EN
        else if (o == 8 * N) begin
            m_en = int'(d) & 1;
        end
`endif
    endtask

    // A tick seen in cycle c either starts a frame (busy c+1..c+LAT, sample at
    // c+LAT, voice v address visible at c+2+3v) or, inside a frame, is dropped.
    task automatic model_tick(input int c);
        int sum;
        int a;
        int out;
        if (c >= busy_from && c <= busy_until) begin
            if (c < ovr_from) ovr_from = c;
        end else begin
            busy_from  = c + 1;
            busy_until = c + LAT;
            sum = 0;
            for (int v = 0; v < N; v++) begin
                m_acc[v] = (m_acc[v] + m_freq[v]) % (1 << ACC_W);
                a = m_wave[v] * 32 + (m_acc[v] >> (ACC_W - 5));
                q_addr.push_back('{c + 2 + 3 * v, a});
                sum += int'(rom_mem[a]) * m_vol[v];
            end
            out = (sum > 255) ? 255 : sum;
            if (m_en == 0) out = 0;
            q_samp.push_back('{c + LAT, out});
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: sampled on the falling edge, away from DUT updates
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        check("busy", int'(busy), (cyc >= busy_from && cyc <= busy_until) ? 1 : 0);
        check("overrun", int'(overrun), (cyc > ovr_from) ? 1 : 0);
        if (q_addr.size() > 0 && q_addr[0].cyc == cyc) begin
            check("rom_addr", int'(rom_addr), q_addr[0].val);
            void'(q_addr.pop_front());
        end
        if (q_samp.size() > 0 && q_samp[0].cyc == cyc) begin
            check("sample_valid", int'(sample_valid), 1);
            check("sample_out", int'(sample_out), q_samp[0].val);
            void'(q_samp.pop_front());
        end else begin
            check("sample_valid_idle", int'(sample_valid), 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called right after a rising edge)
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_en       = 1'b0;
        ram_addr    = 16'h0000;
        cpu_data    = 8'h00;
        sample_tick = 1'b0;
    endtask

    task automatic set_write(input logic [15:0] a, input logic [7:0] d);
        wr_en    = 1'b1;
        ram_addr = a;
        cpu_data = d;
        model_write(a, d);
    endtask

    task automatic set_tick();
        sample_tick = 1'b1;
        model_tick(cyc);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        next_cycle();
        set_write(a, d);
    endtask

    task automatic do_tick();
        next_cycle();
        set_tick();
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < 256; i++) rom_mem[i] = 4'($urandom);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rst         = 1'b0;
        wr_en       = 1'b0;
        ram_addr    = 16'h0000;
        cpu_data    = 8'h00;
        sample_tick = 1'b0;
        fill_rom_random();
        model_reset();

        idle(2);
        check("reset_sample_out", int'(sample_out), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_sample_valid", int'(sample_valid), 0);
        next_cycle();
        rst = 1'b1;
        idle(2);

        // Silent frame straight out of reset.
        do_tick();
        idle(LAT + 2);

        // Voice 0: freq 0x08000, wave 5, vol F -> first address 0xA1.
        rom_mem[8'hA1] = 4'h4;
        do_write(16'h5043, 8'h08);
        do_write(16'h5045, 8'h05);
        do_write(16'h5046, 8'h0F);
        do_tick();
        idle(LAT + 2);

        // All voices at full volume against an all-F ROM saturate the mix.
        for (int i = 0; i < 256; i++) rom_mem[i] = 4'hF;
        do_write(16'h504E, 8'h0F);
        do_write(16'h5056, 8'h0F);
        do_tick();
        idle(LAT + 2);
        fill_rom_random();

        // Second tick three cycles in is dropped and sets overrun.
        do_tick();
        idle(2);
        do_tick();
        idle(LAT + 2);
        do_tick();
        idle(LAT + 2);

        // Reset four cycles into a frame abandons it.
        do_tick();
        idle(3);
        next_cycle();
        rst = 1'b0;
        model_reset();
        #1;
        check("midreset_sample_out", int'(sample_out), 0);
        check("midreset_rom_addr", int'(rom_addr), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_overrun", int'(overrun), 0);
        check("midreset_sample_valid", int'(sample_valid), 0);
        idle(2);
        next_cycle();
        rst = 1'b1;
        rom_mem[8'hA1] = 4'h4;
        do_write(16'h5043, 8'h08);
        do_write(16'h5045, 8'h05);
        do_write(16'h5046, 8'h0F);
        do_tick();
        idle(LAT + 2);

        // Reserved / out-of-window write, then the master-enable slot.
        do_write(16'h505F, 8'hAF);
        do_tick();
        idle(LAT + 2);
        do_write(BASE + 16'(8 * N), 8'h01);
        do_tick();
        idle(LAT + 2);

        // Random traffic: writes and ticks between frames, occasional
        // stray ticks inside frames.
        for (int it = 0; it < 1500; it++) begin
            int r;
            next_cycle();
            if (cyc >= busy_from && cyc <= busy_until) begin
                if ($urandom_range(0, 19) == 0) set_tick();
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 35) begin
                    if ($urandom_range(0, 9) == 0)
                        set_write(16'($urandom), 8'($urandom));
                    else
                        set_write(BASE + 16'($urandom_range(0, 8 * N + 7)), 8'($urandom));
                end
                if (r >= 25 && r < 50) set_tick();
            end
        end

        idle(LAT + 4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
